// File: rtl/alu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pkg : opcodes, FSM encoding and flag indices for seq_alu (rev 1.0)
// ------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_DIV0  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_alu_if : request/result handshake bundle for seq_alu (rev 1.0)
// ------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out, hi, lo, flags
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out, hi, lo, flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_muldiv_iter : unsigned shift-add multiply / restoring divide (rev 1.0)
// ------------------------------------------------------------------
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic             i_is_div,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [WIDTH-1:0]      o_hi,
  output logic [WIDTH-1:0]      o_lo
);
  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 2);

  logic             r_run, r_div, r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;

  logic [WIDTH-1:0] w_src_hi, w_src_lo, w_b, w_nhi, w_nlo;
  logic             w_div, w_borrow;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;

  // The first step is folded into the start cycle so the result is ready after WIDTH edges.
  assign w_src_hi = r_run ? r_hi  : '0;
  assign w_src_lo = r_run ? r_lo  : i_a;
  assign w_b      = r_run ? r_b   : i_b;
  assign w_div    = r_run ? r_div : i_is_div;

  assign w_sum    = {1'b0, w_src_hi} + (w_src_lo[0] ? {1'b0, w_b} : {(WIDTH+1){1'b0}});
  assign w_shift  = {w_src_hi, w_src_lo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, w_b};
  assign w_borrow = w_diff[WIDTH];

  always_comb begin
    w_nhi = w_sum[WIDTH:1];
    w_nlo = {w_sum[0], w_src_lo[WIDTH-1:1]};
    if (w_div) begin
      w_nhi = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_nlo = {w_src_lo[WIDTH-2:0], ~w_borrow};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_div  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        r_b   <= i_b;
        r_div <= i_is_div;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_alu : multi-cycle ALU with valid/ready handshakes and HI:LO result (rev 1.0)
// ------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input wire logic clk,
  input wire logic rst,
  seq_alu_if.slave bus
);
  localparam logic [WIDTH-1:0] C_ONES = '1;
  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, r_hi;
  logic [3:0]       r_flags;
  logic [2:0]       r_op;
  logic             r_neg_q, r_neg_r, r_div_ovf;

  logic             w_accept, w_start, w_div0, w_a_neg, w_b_neg, w_lt;
  logic             w_in_ready, w_out_valid;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_res, w_hi, w_quo, w_rem;
  logic [WIDTH:0]   w_add, w_sub;
  logic [3:0]       w_fl, w_fl_iter;
  logic             w_it_done;
  logic [WIDTH-1:0] w_it_hi, w_it_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_div0   = (bus.op == OP_DIV) && (bus.in2 == '0);
  assign w_start  = w_accept && !w_div0 && ((bus.op == OP_MUL) || (bus.op == OP_DIV));

  // The iterator works on magnitudes; signs are re-applied when the result is captured.
  assign w_a_neg = SIGNED && bus.in1[WIDTH-1];
  assign w_b_neg = SIGNED && bus.in2[WIDTH-1];
  assign w_mag_a = w_a_neg ? -bus.in1 : bus.in1;
  assign w_mag_b = w_b_neg ? -bus.in2 : bus.in2;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_is_div (bus.op == OP_DIV),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_done   (w_it_done),
    .o_hi     (w_it_hi),
    .o_lo     (w_it_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (w_accept) w_state_nxt = w_start ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: if (w_it_done) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_add = {1'b0, bus.in1} + {1'b0, bus.in2};
  assign w_sub = {1'b0, bus.in1} - {1'b0, bus.in2};
  assign w_lt  = SIGNED ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);

  always_comb begin
    w_res = '0;
    w_hi  = '0;
    w_fl  = '0;
    case (bus.op)
      OP_ADD: begin
        w_res            = w_add[WIDTH-1:0];
        w_fl[FLAG_CARRY] = w_add[WIDTH];
        w_fl[FLAG_OVF]   = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                           (w_add[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res            = w_sub[WIDTH-1:0];
        w_fl[FLAG_CARRY] = w_sub[WIDTH];
        w_fl[FLAG_OVF]   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                           (w_sub[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      OP_DIV: begin
        w_res           = C_ONES;
        w_hi            = bus.in1;
        w_fl[FLAG_DIV0] = 1'b1;
      end
      OP_AND:  w_res = bus.in1 & bus.in2;
      OP_OR:   w_res = bus.in1 | bus.in2;
      OP_XOR:  w_res = bus.in1 ^ bus.in2;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_res = '0;
    endcase
    w_fl[FLAG_ZERO] = (w_res == '0);
  end

  assign w_prod = r_neg_q ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};
  assign w_quo  = r_neg_q ? -w_it_lo : w_it_lo;
  assign w_rem  = r_neg_r ? -w_it_hi : w_it_hi;

  always_comb begin
    w_fl_iter = '0;
    if (r_op == OP_MUL) begin
      w_fl_iter[FLAG_ZERO] = (w_prod[WIDTH-1:0] == '0);
      w_fl_iter[FLAG_OVF]  = SIGNED ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                                    : (w_prod[2*WIDTH-1:WIDTH] != '0);
    end else begin
      w_fl_iter[FLAG_ZERO] = (w_quo == '0);
      w_fl_iter[FLAG_OVF]  = r_div_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_hi      <= '0;
      r_flags   <= '0;
      r_op      <= OP_ADD;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div_ovf <= 1'b0;
    end else if (w_accept) begin
      r_op      <= bus.op;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_div_ovf <= SIGNED && (bus.in1 == C_MIN) && (bus.in2 == C_ONES);
      if (!w_start) begin
        r_out   <= w_res;
        r_hi    <= w_hi;
        r_flags <= w_fl;
      end
    end else if ((r_state == ST_BUSY) && w_it_done) begin
      r_out   <= (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_quo;
      r_hi    <= (r_op == OP_MUL) ? w_prod[2*WIDTH-1:WIDTH] : w_rem;
      r_flags <= w_fl_iter;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_out;
  assign bus.lo        = r_out;
  assign bus.hi        = r_hi;
  assign bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_seq_alu : directed vectors against an unsigned and a signed seq_alu (rev 1.0)
// ------------------------------------------------------------------
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] in1, in2;
  int           vectors = 0;
  int           miscompares = 0;
  int           lat;
  bit           rdy_low;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus_u ();
  seq_alu_if #(.WIDTH(W)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.op        = op;
  assign bus_u.in1       = in1;
  assign bus_u.in2       = in2;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.op        = op;
  assign bus_s.in1       = in1;
  assign bus_s.in2       = in2;
  assign bus_s.out_ready = out_ready;

  seq_alu #(.WIDTH(W), .SIGNED(1'b0)) u_dut (.clk(clk), .rst(rst), .bus(bus_u));
  seq_alu #(.WIDTH(W), .SIGNED(1'b1)) s_dut (.clk(clk), .rst(rst), .bus(bus_s));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; lat counts edges from accept.
  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    tick;
    in_valid = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!bus_u.out_valid && lat < 100) begin
      if (bus_u.in_ready || bus_s.in_ready) rdy_low = 1'b0;
      tick;
      lat++;
    end
    if (bus_u.in_ready || bus_s.in_ready) rdy_low = 1'b0;
  endtask

  task automatic expect_res(input string tag,
                            input logic [W-1:0] uh, input logic [W-1:0] ul, input logic [3:0] uf,
                            input logic [W-1:0] sh, input logic [W-1:0] sl, input logic [3:0] sf);
    chk({tag, " u hi:lo"}, {bus_u.hi, bus_u.lo}, {uh, ul});
    chk({tag, " u out"},   bus_u.out, ul);
    chk({tag, " u flags"}, bus_u.flags, uf);
    chk({tag, " s valid"}, bus_s.out_valid, 1);
    chk({tag, " s hi:lo"}, {bus_s.hi, bus_s.lo}, {sh, sl});
    chk({tag, " s out"},   bus_s.out, sl);
    chk({tag, " s flags"}, bus_s.flags, sf);
  endtask

  task automatic release_res(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " back to idle"}, {bus_u.in_ready, bus_u.out_valid, bus_s.in_ready, bus_s.out_valid}, 4'b1010);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = OP_ADD; in1 = '0; in2 = '0;
    repeat (2) tick;
    rst = 1'b0;
    chk("reset handshake", {bus_u.in_ready, bus_u.out_valid, bus_s.in_ready, bus_s.out_valid}, 4'b1010);
    chk("reset u data", {bus_u.out, bus_u.hi, bus_u.lo, bus_u.flags}, 52'h0);
    chk("reset s data", {bus_s.out, bus_s.hi, bus_s.lo, bus_s.flags}, 52'h0);

    run(OP_ADD, 16'hFFFF, 16'h0001);
    chk("ADD latency", lat, 1);
    expect_res("ADD wrap", 16'h0000, 16'h0000, 4'b1100, 16'h0000, 16'h0000, 4'b1100);
    release_res("ADD");

    run(OP_SUB, 16'h8000, 16'h0001);
    expect_res("SUB ovf", 16'h0000, 16'h7FFF, 4'b0010, 16'h0000, 16'h7FFF, 4'b0010);
    release_res("SUB");

    run(OP_SUB, 16'h0003, 16'h0005);
    expect_res("SUB borrow", 16'h0000, 16'hFFFE, 4'b0100, 16'h0000, 16'hFFFE, 4'b0100);
    release_res("SUB2");

    run(OP_SLT, 16'h0003, 16'h0005);
    expect_res("SLT 3<5", 16'h0000, 16'h0001, 4'b0000, 16'h0000, 16'h0001, 4'b0000);
    release_res("SLT");

    run(OP_SLT, 16'hFFFF, 16'h0001);
    expect_res("SLT -1<1", 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0001, 4'b0000);
    release_res("SLT2");

    run(OP_AND, 16'hF0F0, 16'h0FF0);
    expect_res("AND", 16'h0000, 16'h00F0, 4'b0000, 16'h0000, 16'h00F0, 4'b0000);
    release_res("AND");

    run(OP_OR, 16'h1200, 16'h0034);
    expect_res("OR", 16'h0000, 16'h1234, 4'b0000, 16'h0000, 16'h1234, 4'b0000);
    release_res("OR");

    run(OP_MUL, 16'h1234, 16'h0100);
    chk("MUL latency", lat, 17);
    chk("MUL in_ready low", rdy_low, 1);
    expect_res("MUL", 16'h0012, 16'h3400, 4'b0010, 16'h0012, 16'h3400, 4'b0010);
    release_res("MUL");

    run(OP_MUL, 16'hFFFF, 16'h0002);
    expect_res("MUL neg", 16'h0001, 16'hFFFE, 4'b0010, 16'hFFFF, 16'hFFFE, 4'b0000);
    release_res("MUL2");

    run(OP_DIV, 16'd100, 16'd7);
    chk("DIV latency", lat, 17);
    expect_res("DIV 100/7", 16'h0002, 16'h000E, 4'b0000, 16'h0002, 16'h000E, 4'b0000);
    release_res("DIV");

    run(OP_DIV, 16'd5, 16'd0);
    chk("DIV0 latency", lat, 1);
    expect_res("DIV 5/0", 16'h0005, 16'hFFFF, 4'b0001, 16'h0005, 16'hFFFF, 4'b0001);
    release_res("DIV0");

    run(OP_DIV, 16'hFFF9, 16'h0002);
    expect_res("DIV -7/2", 16'h0001, 16'h7FFC, 4'b0000, 16'hFFFF, 16'hFFFD, 4'b0000);
    release_res("DIV3");

    run(OP_DIV, 16'h8000, 16'hFFFF);
    expect_res("DIV min/-1", 16'h8000, 16'h0000, 4'b1000, 16'h0000, 16'h8000, 4'b0010);
    release_res("DIV4");

    // Result must hold through a stalled consumer while new requests are ignored.
    run(OP_XOR, 16'h00FF, 16'h0F0F);
    in_valid = 1'b1; op = OP_AND; in1 = 16'h1111; in2 = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      chk("hold handshake", {bus_u.in_ready, bus_u.out_valid, bus_s.in_ready, bus_s.out_valid}, 4'b0101);
      chk("hold data", {bus_u.out, bus_s.out}, {16'h0FF0, 16'h0FF0});
      tick;
    end
    in_valid = 1'b0;
    release_res("hold");
    chk("hold ignored req", {bus_u.out, bus_s.out}, {16'h0FF0, 16'h0FF0});

    in_valid = 1'b1; op = OP_MUL; in1 = 16'h1234; in2 = 16'h0100;
    tick;
    in_valid = 1'b0;
    repeat (7) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort handshake", {bus_u.in_ready, bus_u.out_valid, bus_s.in_ready, bus_s.out_valid}, 4'b1010);
    chk("abort u data", {bus_u.out, bus_u.hi, bus_u.lo, bus_u.flags}, 52'h0);
    chk("abort s data", {bus_s.out, bus_s.hi, bus_s.lo, bus_s.flags}, 52'h0);

    run(OP_ADD, 16'd2, 16'd3);
    chk("post-abort latency", lat, 1);
    expect_res("ADD 2+3", 16'h0000, 16'h0005, 4'b0000, 16'h0000, 16'h0005, 4'b0000);
    release_res("ADD2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
